// File: rtl/demux_8_dispatch_if.sv
// Handshake bundle for the 1-to-8 distributor: one upstream word port and
// eight per-channel holding-register outputs.
interface demux_8_dispatch_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned N_CH = 8;

    logic                    nCS;
    logic [2:0]              addr;
    logic                    bcast;
    logic [WIDTH-1:0]        din;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_CH*WIDTH-1:0]   out_data;
    logic [N_CH-1:0]         out_valid;
    logic [N_CH-1:0]         out_ready;

    // Upstream producer and downstream consumers drive through master.
    modport master (
        output nCS, addr, bcast, din, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  nCS, addr, bcast, din, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_8_dispatch.sv
// Registered 1-to-8 distributor: one-entry holding register per channel,
// addressed or broadcast writes, and an accepted-word counter.
module demux_8_dispatch #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               nRST,
    demux_8_dispatch_if.slave  bus,
    output logic [CNT_W-1:0]   acc_cnt
);
    localparam int unsigned N_CH = 8;

    logic [N_CH-1:0]       slot_free_c;
    logic [N_CH-1:0]       load_c;
    logic                  in_ready_c;
    logic                  accept_c;

    logic [N_CH-1:0]       valid_d, valid_q;
    logic [N_CH*WIDTH-1:0] data_d,  data_q;
    logic [CNT_W-1:0]      cnt_d,   cnt_q;

    // Acceptance: a slot draining this cycle counts as free; broadcast needs all.
    always_comb begin
        slot_free_c = ~valid_q | bus.out_ready;
        in_ready_c  = 1'b0;
        if (!bus.nCS) begin
            if (bus.bcast) in_ready_c = &slot_free_c;
            else           in_ready_c = slot_free_c[bus.addr];
        end
        accept_c = bus.in_valid & in_ready_c;
        load_c   = '0;
        if (accept_c) begin
            if (bus.bcast) load_c = '1;
            else           load_c = N_CH'(1) << bus.addr;
        end
    end

    // Per-channel full/empty next state and data capture.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (load_c[i]) begin
                valid_d[i]              = 1'b1;
                data_d[i*WIDTH +: WIDTH] = bus.din;
            end else if (bus.out_ready[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (accept_c) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign acc_cnt       = cnt_q;
endmodule

// File: tb/tb_demux_8_dispatch.sv
// Scoreboard bench for demux_8_dispatch: per-channel expected-word queues,
// directed scenarios followed by a constrained-random phase.
module tb_demux_8_dispatch;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic nRST;
    logic [CNT_W-1:0] acc_cnt;

    demux_8_dispatch_if #(.WIDTH(WIDTH)) bus ();

    demux_8_dispatch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .nRST    (nRST),
        .bus     (bus),
        .acc_cnt (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    logic [WIDTH-1:0] exp_q [8][$];
    logic [7:0]       m_valid;
    logic [CNT_W-1:0] m_cnt;
    logic             m_accept;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ch_data(input int i);
        logic [63:0] all;
        all = bus.out_data;
        return all[i*WIDTH +: WIDTH];
    endfunction

    // One clock: check pre-edge view against the model, advance model, check post-edge.
    task automatic cycle();
        logic [7:0] free;
        logic       exp_ready;
        logic [7:0] load;
        bit         rst;
        #1;
        rst  = !nRST;
        free = ~m_valid | bus.out_ready;
        if (bus.nCS)        exp_ready = 1'b0;
        else if (bus.bcast) exp_ready = &free;
        else                exp_ready = free[bus.addr];
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_empty: ch %0d valid with no expected word", i);
                end else begin
                    check($sformatf("ch%0d_data", i), 64'(ch_data(i)), 64'(exp_q[i][0]));
                end
            end
        end
        m_accept = bus.in_valid && exp_ready;
        load = '0;
        if (m_accept) load = bus.bcast ? 8'hFF : (8'h01 << bus.addr);
        if (rst) begin
            for (int i = 0; i < 8; i++) exp_q[i].delete();
            m_valid  = '0;
            m_cnt    = '0;
            m_accept = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (m_valid[i] && bus.out_ready[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
                if (load[i]) exp_q[i].push_back(bus.din);
            end
            m_valid = (m_valid & ~bus.out_ready) | load;
            if (m_accept) m_cnt = m_cnt + CNT_W'(1);
        end
        @(posedge clk);
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("acc_cnt",   64'(acc_cnt),       64'(m_cnt));
        if (rst) check("rst_data", 64'(bus.out_data), 64'(0));
        @(negedge clk);
    endtask

    task automatic drive(input logic ncs, input logic [2:0] a, input logic b,
                         input logic [WIDTH-1:0] d, input logic v, input logic [7:0] rdy);
        bus.nCS = ncs; bus.addr = a; bus.bcast = b; bus.din = d;
        bus.in_valid = v; bus.out_ready = rdy;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_valid = '0; m_cnt = '0; m_accept = 1'b0;
        nRST = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(); cycle();
        nRST = 1'b1;
        check("reset_valid", 64'(bus.out_valid), 64'h0);
        check("reset_cnt",   64'(acc_cnt),       64'h0);

        // Single write to channel 3, then drain.
        drive(1'b0, 3'd3, 1'b0, 8'hA5, 1'b1, 8'h00); cycle();
        drive(1'b0, 3'd3, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wr_valid", 64'(bus.out_valid), 64'h08);
        check("wr_data3", 64'(ch_data(3)),    64'hA5);
        check("wr_cnt",   64'(acc_cnt),       64'd1);
        bus.out_ready = 8'h08; cycle();
        bus.out_ready = 8'h00;
        check("wr_drained", 64'(bus.out_valid), 64'h00);
        check("wr_retain",  64'(ch_data(3)),    64'hA5);

        // Backpressure on channel 5, then same-edge drain+load.
        drive(1'b0, 3'd5, 1'b0, 8'h11, 1'b1, 8'h00); cycle();
        drive(1'b0, 3'd5, 1'b0, 8'h22, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            #1 check("bp_ready", 64'(bus.in_ready), 64'h0);
            check("bp_hold5", 64'(ch_data(5)), 64'h11);
            cycle();
        end
        bus.out_ready = 8'h20; cycle();
        drive(1'b0, 3'd5, 1'b0, 8'h00, 1'b0, 8'h00);
        check("bp_valid", 64'(bus.out_valid[5]), 64'h1);
        check("bp_data5", 64'(ch_data(5)),       64'h22);
        check("bp_cnt",   64'(acc_cnt),          64'd3);
        bus.out_ready = 8'hFF; cycle();

        // Broadcast into empty channels, then a stalled broadcast.
        drive(1'b0, 3'd0, 1'b1, 8'h5A, 1'b1, 8'h00); cycle();
        bus.in_valid = 1'b0;
        check("bc_valid", 64'(bus.out_valid), 64'hFF);
        check("bc_data",  64'(bus.out_data),  64'h5A5A5A5A5A5A5A5A);
        check("bc_cnt",   64'(acc_cnt),       64'd4);
        bus.out_ready = 8'hFE; cycle();
        drive(1'b0, 3'd0, 1'b1, 8'h77, 1'b1, 8'h00);
        #1 check("bc_stall", 64'(bus.in_ready), 64'h0);
        cycle();
        check("bc_nochg", 64'(bus.out_valid), 64'h01);
        check("bc_d0",    64'(ch_data(0)),    64'h5A);
        check("bc_d1",    64'(ch_data(1)),    64'h5A);
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'hFF); cycle();

        // Chip select blocks acceptance while channel 7 still drains.
        drive(1'b0, 3'd7, 1'b0, 8'h3C, 1'b1, 8'h00); cycle();
        drive(1'b1, 3'd2, 1'b0, 8'h99, 1'b1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.out_ready = 8'h80;
            #1 check("cs_ready", 64'(bus.in_ready), 64'h0);
            cycle();
        end
        check("cs_cnt",   64'(acc_cnt),       64'd5);
        check("cs_drain", 64'(bus.out_valid), 64'h00);

        // Counter wrap: 17 accepts after reset gives 1 on a 4-bit counter.
        nRST = 1'b0; drive(1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00); cycle();
        nRST = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(1'b0, 3'(k % 8), 1'b0, 8'(8'h40 + k), 1'b1, 8'hFF);
            cycle();
        end
        check("wrap_cnt", 64'(acc_cnt), 64'd1);
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'hFF); cycle();

        // Reset mid-operation with out_valid=3C and acc_cnt=9.
        nRST = 1'b0; cycle(); nRST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 3'd0, 1'b0, 8'(k), 1'b1, 8'h01); cycle();
        end
        drive(1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h01); cycle();
        for (int k = 2; k < 6; k++) begin
            drive(1'b0, 3'(k), 1'b0, 8'(8'hC0 + k), 1'b1, 8'h00); cycle();
        end
        check("pre_rst_valid", 64'(bus.out_valid), 64'h3C);
        check("pre_rst_cnt",   64'(acc_cnt),       64'd9);
        drive(1'b0, 3'd0, 1'b0, 8'hEE, 1'b1, 8'h00);
        nRST = 1'b0; cycle(); nRST = 1'b1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'h00);
        check("mid_rst_data",  64'(bus.out_data),  64'h0);
        check("mid_rst_cnt",   64'(acc_cnt),       64'd0);

        // Random traffic; upstream holds its word stable until accepted.
        drive(1'b0, 3'($urandom_range(7)), 1'b0, 8'($urandom), 1'b1, 8'h00);
        for (int k = 0; k < 400; k++) begin
            bus.out_ready = 8'($urandom);
            bus.nCS       = ($urandom_range(9) == 0);
            cycle();
            if (m_accept || !bus.in_valid) begin
                bus.in_valid = ($urandom_range(3) != 0);
                bus.addr     = 3'($urandom_range(7));
                bus.bcast    = ($urandom_range(7) == 0);
                bus.din      = 8'($urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
